// File: rtl/operand_fetch_pkg.sv
// Shared types and constants for the operand-fetch stage: ALU opcodes, data and index widths.
// The OPFETCH_IMM_EN build uses imm_extend() to form an immediate B operand.
package operand_fetch_pkg;

    localparam int NREG  = 32;
    localparam int DW    = 32;
    localparam int IDX_W = $clog2(NREG);
    localparam int IMM_W = 16;

    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_AND = 3'd2,
        ALU_OR  = 3'd3,
        ALU_SRL = 3'd4,
        ALU_SRA = 3'd5
    } alu_op_e;

    function automatic logic [DW-1:0] imm_extend(input logic [IMM_W-1:0] imm, input logic sext);
        return sext ? {{(DW-IMM_W){imm[IMM_W-1]}}, imm} : {{(DW-IMM_W){1'b0}}, imm};
    endfunction

endpackage

// File: rtl/operand_fetch_if.sv
// Issue-side, ALU-side and write-back signals of the operand-fetch stage.
// With OPFETCH_IMM_EN defined, the immediate-operand inputs are added.
interface operand_fetch_if;
    import operand_fetch_pkg::*;

    logic             in_valid;
    logic             in_ready;
    logic [IDX_W-1:0] in_rs;
    logic [IDX_W-1:0] in_rt;
    logic [IDX_W-1:0] in_rd;
    logic [2:0]       in_aluop;
`ifdef OPFETCH_IMM_EN
    logic             in_use_imm;
    logic [IMM_W-1:0] in_imm;
    logic             in_imm_sext;
`endif
    logic             out_valid;
    logic             out_ready;
    logic [DW-1:0]    out_a;
    logic [DW-1:0]    out_b;
    logic [2:0]       out_aluop;
    logic [IDX_W-1:0] out_rd;
    logic             wb_we;
    logic [IDX_W-1:0] wb_addr;
    logic [DW-1:0]    wb_data;

    modport master (
        output in_valid, in_rs, in_rt, in_rd, in_aluop,
`ifdef OPFETCH_IMM_EN
        output in_use_imm, in_imm, in_imm_sext,
`endif
        output out_ready, wb_we, wb_addr, wb_data,
        input  in_ready, out_valid, out_a, out_b, out_aluop, out_rd
    );

    modport slave (
        input  in_valid, in_rs, in_rt, in_rd, in_aluop,
`ifdef OPFETCH_IMM_EN
        input  in_use_imm, in_imm, in_imm_sext,
`endif
        input  out_ready, wb_we, wb_addr, wb_data,
        output in_ready, out_valid, out_a, out_b, out_aluop, out_rd
    );

endinterface

// File: rtl/operand_fetch_grf.sv
// General register file: NREG x DW, one write port, two combinational read ports.
// Register 0 is hardwired to zero; writes to it are dropped.
module operand_fetch_grf
    import operand_fetch_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             i_we,
    input  logic [IDX_W-1:0] i_waddr,
    input  logic [DW-1:0]    i_wdata,
    input  logic [IDX_W-1:0] i_raddr_a,
    input  logic [IDX_W-1:0] i_raddr_b,
    output logic [DW-1:0]    o_rdata_a,
    output logic [DW-1:0]    o_rdata_b
);

    logic [DW-1:0] r_regs [NREG];

    // NOTE: the whole array is reset, so it maps to flops rather than RAM; the stage must
    // come out of reset with every architectural register reading zero.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NREG; i++) begin
                r_regs[i] <= '0;
            end
        end else if (i_we && i_waddr != '0) begin
            r_regs[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata_a = (i_raddr_a == '0) ? '0 : r_regs[i_raddr_a];
    assign o_rdata_b = (i_raddr_b == '0) ? '0 : r_regs[i_raddr_b];

endmodule

// File: rtl/operand_fetch.sv
// Operand-fetch / issue stage: reads rs/rt with write-back bypass into a single-entry issue
// register facing the ALU. Optional immediate B operand under OPFETCH_IMM_EN.
module operand_fetch
    import operand_fetch_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    operand_fetch_if.slave bus
);

    logic [DW-1:0]    w_grf_a;
    logic [DW-1:0]    w_grf_b;
    logic [DW-1:0]    w_op_a;
    logic [DW-1:0]    w_op_b;
    logic             w_accept;
    logic             w_wb_live;
    logic             w_b_refresh_en;

    logic             r_valid;
    logic [DW-1:0]    r_a;
    logic [DW-1:0]    r_b;
    logic [2:0]       r_aluop;
    logic [IDX_W-1:0] r_rd;
    logic [IDX_W-1:0] r_rs;
    logic [IDX_W-1:0] r_rt;
`ifdef OPFETCH_IMM_EN
    logic             r_imm;
`endif

    operand_fetch_grf u_grf (
        .clk       (clk),
        .reset     (reset),
        .i_we      (bus.wb_we),
        .i_waddr   (bus.wb_addr),
        .i_wdata   (bus.wb_data),
        .i_raddr_a (bus.in_rs),
        .i_raddr_b (bus.in_rt),
        .o_rdata_a (w_grf_a),
        .o_rdata_b (w_grf_b)
    );

    assign w_wb_live = bus.wb_we && (bus.wb_addr != '0);
    assign bus.in_ready = !r_valid || bus.out_ready;
    assign w_accept  = bus.in_valid && bus.in_ready;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        w_op_a = w_grf_a;
        w_op_b = w_grf_b;
        if (w_wb_live && bus.wb_addr == bus.in_rs) w_op_a = bus.wb_data;
        if (w_wb_live && bus.wb_addr == bus.in_rt) w_op_b = bus.wb_data;
`ifdef OPFETCH_IMM_EN
        if (bus.in_use_imm) w_op_b = imm_extend(bus.in_imm, bus.in_imm_sext);
`endif
    end

`ifdef OPFETCH_IMM_EN
    assign w_b_refresh_en = !r_imm;
`else
    assign w_b_refresh_en = 1'b1;
`endif

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_valid <= 1'b0;
            r_a     <= '0;
            r_b     <= '0;
            r_aluop <= '0;
            r_rd    <= '0;
            r_rs    <= '0;
            r_rt    <= '0;
`ifdef OPFETCH_IMM_EN
            r_imm   <= 1'b0;
`endif
        end else if (w_accept) begin
            r_valid <= 1'b1;
            r_a     <= w_op_a;
            r_b     <= w_op_b;
            r_aluop <= bus.in_aluop;
            r_rd    <= bus.in_rd;
            r_rs    <= bus.in_rs;
            r_rt    <= bus.in_rt;
`ifdef OPFETCH_IMM_EN
            r_imm   <= bus.in_use_imm;
`endif
        end else if (r_valid && bus.out_ready) begin
            r_valid <= 1'b0;
        end else if (r_valid) begin
            // Stalled entry tracks later writes to its sources so it never issues stale data.
            if (w_wb_live && bus.wb_addr == r_rs) r_a <= bus.wb_data;
            if (w_wb_live && w_b_refresh_en && bus.wb_addr == r_rt) r_b <= bus.wb_data;
        end
    end

    assign bus.out_valid = r_valid;
    assign bus.out_a     = r_a;
    assign bus.out_b     = r_b;
    assign bus.out_aluop = r_aluop;
    assign bus.out_rd    = r_rd;

endmodule

// File: tb/tb_operand_fetch.sv
// Self-checking bench for operand_fetch: vector table of back-to-back issues plus
// directed sequences for backpressure/refresh, streaming and asynchronous reset.
module tb_operand_fetch;
    import operand_fetch_pkg::*;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_errors;

    operand_fetch_if bus ();

    operand_fetch dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       we;
        logic [4:0] wa;
        logic [31:0] wd;
        logic [4:0] rs;
        logic [4:0] rt;
        logic [4:0] rd;
        logic [2:0] op;
        logic [31:0] ea;
        logic [31:0] eb;
    } vec_t;

    vec_t vecs [7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Advance one clock; samples taken afterwards are 1 time unit past the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                         input logic [2:0] op);
        bus.in_valid = 1'b1;
        bus.in_rs    = rs;
        bus.in_rt    = rt;
        bus.in_rd    = rd;
        bus.in_aluop = op;
    endtask

    task automatic wb(input logic we, input logic [4:0] addr, input logic [31:0] data);
        bus.wb_we   = we;
        bus.wb_addr = addr;
        bus.wb_data = data;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;

        vecs[0] = '{1'b0, 5'd0,  32'h0,         5'd5,  5'd6,  5'd9,  ALU_SUB, 32'h0000_1234, 32'hFFFF_0001};
        vecs[1] = '{1'b1, 5'd7,  32'hDEAD_BEEF, 5'd7,  5'd0,  5'd10, ALU_ADD, 32'hDEAD_BEEF, 32'h0};
        vecs[2] = '{1'b1, 5'd0,  32'hFFFF_FFFF, 5'd0,  5'd7,  5'd11, ALU_AND, 32'h0,         32'hDEAD_BEEF};
        vecs[3] = '{1'b0, 5'd0,  32'h0,         5'd0,  5'd0,  5'd12, ALU_OR,  32'h0,         32'h0};
        vecs[4] = '{1'b1, 5'd31, 32'hA5A5_5A5A, 5'd31, 5'd31, 5'd31, ALU_SRL, 32'hA5A5_5A5A, 32'hA5A5_5A5A};
        vecs[5] = '{1'b1, 5'd5,  32'hCAFE_F00D, 5'd6,  5'd5,  5'd1,  ALU_SRA, 32'hFFFF_0001, 32'hCAFE_F00D};
        vecs[6] = '{1'b0, 5'd0,  32'h0,         5'd5,  5'd31, 5'd0,  3'd7,    32'hCAFE_F00D, 32'hA5A5_5A5A};

        reset         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_rs     = '0;
        bus.in_rt     = '0;
        bus.in_rd     = '0;
        bus.in_aluop  = '0;
        bus.out_ready = 1'b0;
        wb(1'b0, 5'd0, 32'h0);
`ifdef OPFETCH_IMM_EN
        bus.in_use_imm  = 1'b0;
        bus.in_imm      = '0;
        bus.in_imm_sext = 1'b0;
`endif

        // Reset state
        #3;
        check("rst_out_valid", 32'(bus.out_valid), 32'h0);
        check("rst_out_a",     bus.out_a,          32'h0);
        check("rst_out_b",     bus.out_b,          32'h0);
        check("rst_out_aluop", 32'(bus.out_aluop), 32'h0);
        check("rst_out_rd",    32'(bus.out_rd),    32'h0);
        check("rst_in_ready",  32'(bus.in_ready),  32'h1);
        tick();
        tick();
        reset = 1'b1;

        // Preload reg5 and reg6
        wb(1'b1, 5'd5, 32'h0000_1234);
        tick();
        wb(1'b1, 5'd6, 32'hFFFF_0001);
        tick();
        wb(1'b0, 5'd0, 32'h0);
        check("idle_out_valid", 32'(bus.out_valid), 32'h0);

        // Vector table: back-to-back issues with out_ready held high
        bus.out_ready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            wb(vecs[i].we, vecs[i].wa, vecs[i].wd);
            issue(vecs[i].rs, vecs[i].rt, vecs[i].rd, vecs[i].op);
            tick();
            check($sformatf("vec%0d_valid", i), 32'(bus.out_valid), 32'h1);
            check($sformatf("vec%0d_a", i),     bus.out_a,          vecs[i].ea);
            check($sformatf("vec%0d_b", i),     bus.out_b,          vecs[i].eb);
            check($sformatf("vec%0d_aluop", i), 32'(bus.out_aluop), 32'(vecs[i].op));
            check($sformatf("vec%0d_rd", i),    32'(bus.out_rd),    32'(vecs[i].rd));
        end
        bus.in_valid = 1'b0;
        wb(1'b0, 5'd0, 32'h0);
        tick();
        check("retire_out_valid", 32'(bus.out_valid), 32'h0);

        // Backpressure with held-operand refresh
        bus.out_ready = 1'b0;
        issue(5'd3, 5'd4, 5'd2, ALU_ADD);
        tick();
        check("bp_valid", 32'(bus.out_valid), 32'h1);
        check("bp_a0",    bus.out_a,          32'h0);
        issue(5'd5, 5'd6, 5'd3, ALU_SUB);
        wb(1'b1, 5'd3, 32'h0000_0055);
        #1;
        check("bp_in_ready", 32'(bus.in_ready), 32'h0);
        tick();
        check("bp_refresh_a", bus.out_a,          32'h0000_0055);
        check("bp_b_kept",    bus.out_b,          32'h0);
        check("bp_rd_kept",   32'(bus.out_rd),    32'h2);
        wb(1'b1, 5'd4, 32'h0000_0066);
        tick();
        check("bp_refresh_b", bus.out_b,          32'h0000_0066);
        check("bp_a_kept",    bus.out_a,          32'h0000_0055);
        check("bp_aluop",     32'(bus.out_aluop), 32'(ALU_ADD));
        wb(1'b1, 5'd0, 32'h1111_1111);
        tick();
        check("bp_r0_no_refresh", bus.out_a,      32'h0000_0055);
        wb(1'b0, 5'd0, 32'h0);
        bus.out_ready = 1'b1;
        #1;
        check("bp_in_ready_rel", 32'(bus.in_ready), 32'h1);
        tick();
        check("bp_next_valid", 32'(bus.out_valid), 32'h1);
        check("bp_next_rd",    32'(bus.out_rd),    32'h3);
        check("bp_next_a",     bus.out_a,          32'hCAFE_F00D);
        check("bp_next_b",     bus.out_b,          32'hFFFF_0001);
        bus.in_valid = 1'b0;
        tick();
        check("bp_drain", 32'(bus.out_valid), 32'h0);

        // Streaming: eight back-to-back issues, one result per cycle, in order
        for (int i = 1; i <= 8; i++) begin
            issue(5'd5, 5'd3, 5'(i), ALU_OR);
            #1;
            check($sformatf("st%0d_in_ready", i), 32'(bus.in_ready), 32'h1);
            tick();
            check($sformatf("st%0d_valid", i), 32'(bus.out_valid), 32'h1);
            check($sformatf("st%0d_rd", i),    32'(bus.out_rd),    32'(i));
        end
        check("st_a", bus.out_a, 32'hCAFE_F00D);
        check("st_b", bus.out_b, 32'h0000_0055);
        bus.in_valid = 1'b0;
        tick();
        check("st_drain", 32'(bus.out_valid), 32'h0);

        // Asynchronous reset while stalled
        bus.out_ready = 1'b0;
        issue(5'd3, 5'd4, 5'd4, ALU_SRA);
        tick();
        bus.in_valid = 1'b0;
        check("ar_valid_before", 32'(bus.out_valid), 32'h1);
        check("ar_a_before",     bus.out_a,          32'h0000_0055);
        #2;
        reset = 1'b0;
        #1;
        check("ar_valid_async", 32'(bus.out_valid), 32'h0);
        check("ar_a_async",     bus.out_a,          32'h0);
        tick();
        reset = 1'b1;
        bus.out_ready = 1'b1;
        issue(5'd3, 5'd4, 5'd5, ALU_ADD);
        tick();
        bus.in_valid = 1'b0;
        check("ar_post_valid", 32'(bus.out_valid), 32'h1);
        check("ar_post_reg3",  bus.out_a,          32'h0);
        check("ar_post_reg4",  bus.out_b,          32'h0);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
